instruction_fetch_unit: RTL and testbench



---
 rtl/fetch_pkg.sv | 26 ++
 rtl/fetch_fifo.sv | 70 +++++++
 rtl/instruction_fetch_unit.sv | 136 +++++++++++++
 tb/tb_instruction_fetch_unit.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction fetch unit: opcodes, FSM states,
// buffered entry layout and the J-type immediate decoder.
package fetch_pkg;

  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } fetch_state_t;

  // Entry layout for the default 64-bit PC / 32-bit instruction configuration.
  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
    logic        pred_taken;
  } fetch_entry_t;

  function automatic logic [63:0] imm_j(input logic [31:0] instr);
    return {{44{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small fetch buffer: power-of-two depth, combinational head read,
// synchronous flush that discards any same-edge push or pop.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [W-1:0]           push_data,
  input  logic                   pop,
  input  logic                   flush,
  output logic [W-1:0]           head_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; the consumer masks the head while empty.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= push_data;
  end

  assign head_data = mem_q[rd_ptr_q];
  assign full      = (count_q == DEPTH_C);
  assign empty     = (count_q == '0);
  assign count     = count_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: one outstanding imem request, buffered {pc,instr} delivery to decode,
// execute redirects with response kill. Define JAL_PREDICT_EN for fetch-side JAL following.
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN       = 64,
  parameter int              ILEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [ILEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [ILEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc,
  output logic            if_pred_taken
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int EW = XLEN + ILEN + 1;
  localparam logic [CW-1:0] FIFO_DEPTH_C = CW'(FIFO_DEPTH);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic            kill_q, kill_d;

  logic [XLEN-1:0] target;
  logic            push_en, pop_en, push_pred;
  logic [CW-1:0]   fifo_count, count_after;
  logic            fifo_full, fifo_empty;
  logic [EW-1:0]   head;

  assign target  = redirect_target & ~XLEN'(3);
  assign pop_en  = !fifo_empty && if_ready && !redirect_valid;
  assign push_en = (state_q == WAIT) && imem_rvalid && !kill_q && !redirect_valid && !fifo_full;

`ifdef JAL_PREDICT_EN
  logic [XLEN-1:0] jal_target;
  assign push_pred  = (imem_rdata[6:0] == OPC_JAL);
  assign jal_target = addr_q + XLEN'(imm_j(imem_rdata[31:0]));
`else
  assign push_pred  = 1'b0;
`endif

  // Occupancy after this edge; with nothing outstanding afterwards it is the whole space test.
  always_comb begin
    if (redirect_valid) count_after = '0;
    else                count_after = fifo_count + CW'(push_en) - CW'(pop_en);
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    addr_d     = addr_q;
    kill_d     = kill_q;
    case (state_q)
      IDLE: begin
        if (redirect_valid) fetch_pc_d = target;
        if (count_after < FIFO_DEPTH_C) state_d = REQ;
      end
      REQ: begin
        if (imem_gnt) state_d = WAIT;
        // A pending request cannot be withdrawn, so its response is marked for dropping.
        if (redirect_valid) begin
          fetch_pc_d = target;
          kill_d     = 1'b1;
        end else if (imem_gnt && !kill_q) begin
          fetch_pc_d = addr_q + XLEN'(4);
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          kill_d  = 1'b0;
          state_d = (count_after < FIFO_DEPTH_C) ? REQ : IDLE;
          if (redirect_valid) fetch_pc_d = target;
`ifdef JAL_PREDICT_EN
          else if (push_en && push_pred) fetch_pc_d = jal_target;
`endif
        end else if (redirect_valid) begin
          fetch_pc_d = target;
          kill_d     = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Address is captured on entry to REQ so it stays stable until granted.
    if (state_d == REQ && state_q != REQ) addr_d = fetch_pc_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      addr_q     <= RESET_PC;
      kill_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      kill_q     <= kill_d;
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_en),
    .push_data ({addr_q, imem_rdata, push_pred}),
    .pop       (pop_en),
    .flush     (redirect_valid),
    .head_data (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign imem_req      = (state_q == REQ);
  assign imem_addr     = addr_q;
  assign if_valid      = !fifo_empty;
  assign if_pc         = fifo_empty ? '0 : head[EW-1 -: XLEN];
  assign if_instr      = fifo_empty ? '0 : head[ILEN:1];
  assign if_pred_taken = !fifo_empty && head[0];

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: memory responder, decode-stream
// reference model, directed redirect table and randomized traffic.
module tb_instruction_fetch_unit;

  localparam logic [63:0] RST_PC = 64'h100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [63:0] redirect_target;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [63:0] if_pc;
  logic        if_pred_taken;

  always #5 clk = ~clk;

  instruction_fetch_unit #(
    .XLEN       (64),
    .ILEN       (32),
    .RESET_PC   (RST_PC),
    .FIFO_DEPTH (4)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_gnt        (imem_gnt),
    .imem_rvalid     (imem_rvalid),
    .imem_rdata      (imem_rdata),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .if_valid        (if_valid),
    .if_ready        (if_ready),
    .if_instr        (if_instr),
    .if_pc           (if_pc),
    .if_pred_taken   (if_pred_taken)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_xfer   = 0;

  // responder / driver controls
  int  gnt_prob, ready_prob, lat_min, lat_max;
  bit  jal100_en = 0, jal_rand_en = 0;
  bit  redir_now = 0;
  logic [63:0] redir_tgt = '0;

  // responder state
  bit          pending = 0;
  int          pend_cnt = 0;
  logic [63:0] pend_addr = '0;
  logic [63:0] gnt_log[$];

  // snapshots and previous-cycle protocol state
  logic        s_req, s_valid, p_req, p_gnt;
  logic [63:0] s_addr, p_addr;

  // expected next PC delivered to decode
  logic [63:0] exp_pc;

  typedef struct {
    int          mode;      // 0: WAIT without rvalid, 1: WAIT with rvalid, 2: REQ held without gnt
    logic [63:0] tgt;
    logic [63:0] exp_addr;
  } redir_vec_t;
  redir_vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit mem_is_jal(input logic [63:0] a);
    return (jal100_en && a == 64'h100) || (jal_rand_en && a[6:2] == 5'h1F);
  endfunction

  function automatic logic [63:0] mem_jal_off(input logic [63:0] a);
    return (jal100_en && a == 64'h100) ? 64'h40 : 64'h80;
  endfunction

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    if (mem_is_jal(a)) return (jal100_en && a == 64'h100) ? 32'h0400_00EF : 32'h0800_006F;
    return {a[31:7] ^ 25'h15A5A5, 7'h13};
  endfunction

  // Decode-stream model: delivered PCs run sequentially (or follow predicted JALs)
  // from the last reset or redirect target.
  task automatic model_xfer();
    bit taken;
    chk("xfer_pc", if_pc, exp_pc);
    chk("xfer_instr", {32'h0, if_instr}, {32'h0, mem_word(exp_pc)});
`ifdef JAL_PREDICT_EN
    taken = mem_is_jal(exp_pc);
`else
    taken = 1'b0;
`endif
    chk("xfer_pred", {63'h0, if_pred_taken}, {63'h0, taken});
    $display("xfer pc=%h instr=%h pred=%0d", if_pc, if_instr, if_pred_taken);
    exp_pc = taken ? exp_pc + mem_jal_off(exp_pc) : exp_pc + 64'd4;
    n_xfer++;
  endtask

  task automatic cycle();
    @(negedge clk);
    s_req   = imem_req;
    s_addr  = imem_addr;
    s_valid = if_valid;
    if (p_req && !p_gnt) begin
      chk("req_held", {63'h0, s_req}, 64'h1);
      chk("addr_held", s_addr, p_addr);
    end
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    if (pending) begin
      if (pend_cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(pend_addr);
        pending     = 0;
      end else begin
        pend_cnt--;
      end
    end
    imem_gnt = 1'b0;
    if (s_req) begin
      chk("one_outstanding", {63'h0, pending}, 64'h0);
      if (!pending && int'($urandom_range(99)) < gnt_prob) begin
        imem_gnt  = 1'b1;
        pending   = 1;
        pend_addr = s_addr;
        pend_cnt  = int'($urandom_range(lat_max, lat_min)) - 1;
        gnt_log.push_back(s_addr);
      end
    end
    p_req  = s_req;
    p_gnt  = imem_gnt;
    p_addr = s_addr;
    if_ready        = (int'($urandom_range(99)) < ready_prob);
    redirect_valid  = redir_now;
    redirect_target = redir_tgt;
    if (s_valid && if_ready && !redir_now) model_xfer();
    if (redir_now) exp_pc = redir_tgt & ~64'h3;
    redir_now = 0;
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req"}, {63'h0, imem_req}, 64'h0);
    chk({tag, "_addr"}, imem_addr, RST_PC);
    chk({tag, "_valid"}, {63'h0, if_valid}, 64'h0);
    chk({tag, "_instr"}, {32'h0, if_instr}, 64'h0);
    chk({tag, "_pc"}, if_pc, 64'h0);
    chk({tag, "_pred"}, {63'h0, if_pred_taken}, 64'h0);
  endtask

  task automatic do_reset(input bit keep_pending);
    rst_n = 1'b0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    redirect_valid = 1'b0; redirect_target = '0; if_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    p_req = 1'b0; p_gnt = 1'b0;
    if (!keep_pending) pending = 0;
    gnt_log.delete();
    exp_pc = RST_PC;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, skip, x0;
    bit reached;
    logic [63:0] held;

    vecs[0] = '{0, 64'h2000, 64'h2000};
    vecs[1] = '{1, 64'h3000, 64'h3000};
    vecs[2] = '{2, 64'h4000, 64'h4000};
    vecs[3] = '{0, 64'h5003, 64'h5000};
    vecs[4] = '{1, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFC};
    vecs[5] = '{2, 64'h6001, 64'h6000};

    // sequential fetch, gnt always, latency 2
    gnt_prob = 100; ready_prob = 100; lat_min = 2; lat_max = 2;
    do_reset(0);
    cycle();
    chk("first_req_2nd_cycle", {63'h0, s_req}, 64'h1);
    run(20);
    chk("t1_grant_count_ok", {63'h0, gnt_log.size() >= 3}, 64'h1);
    chk("t1_addr0", gnt_log[0], 64'h100);
    chk("t1_addr1", gnt_log[1], 64'h104);
    chk("t1_addr2", gnt_log[2], 64'h108);
    chk("t1_xfers", {63'h0, n_xfer >= 3}, 64'h1);

    // backpressure: exactly DEPTH grants, then one refill per pop
    ready_prob = 0;
    do_reset(0);
    run(40);
    chk("t2_grants", 64'(gnt_log.size()), 64'd4);
    chk("t2_req_low", {63'h0, s_req}, 64'h0);
    chk("t2_valid_high", {63'h0, s_valid}, 64'h1);
    for (int k = 1; k <= 3; k++) begin
      ready_prob = 100;
      cycle();
      ready_prob = 0;
      run(10);
      chk("t2_refill", 64'(gnt_log.size()), 64'(4 + k));
    end
    ready_prob = 100;
    x0 = n_xfer;
    run(40);
    chk("t2_drain", {63'h0, (n_xfer - x0) >= 10}, 64'h1);

    // redirect scenarios
    for (int v = 0; v < 6; v++) begin
      gnt_prob = 100; lat_min = 3; lat_max = 3; ready_prob = 50;
      held = '0;
      if (vecs[v].mode == 2) gnt_prob = 0;
      reached = 0;
      for (int i = 0; i < 60 && !reached; i++) begin
        cycle();
        case (vecs[v].mode)
          0: reached = pending && pend_cnt >= 1;
          1: reached = pending && pend_cnt == 0;
          default: reached = s_req && !p_gnt;
        endcase
      end
      chk("redir_setup_reached", {63'h0, reached}, 64'h1);
      held = s_addr;
      base = gnt_log.size();
      redir_now = 1;
      redir_tgt = vecs[v].tgt;
      cycle();
      cycle();
      chk("redir_valid_low", {63'h0, s_valid}, 64'h0);
      if (vecs[v].mode == 2) cycle();
      gnt_prob = 100;
      skip = (vecs[v].mode == 2) ? 1 : 0;
      for (int i = 0; i < 60 && gnt_log.size() <= base + skip; i++) cycle();
      chk("redir_grant_seen", {63'h0, gnt_log.size() > base + skip}, 64'h1);
      if (vecs[v].mode == 2) chk("redir_held_grant", gnt_log[base], held);
      chk("redir_next_addr", gnt_log[base + skip], vecs[v].exp_addr);
      run(12);
    end

    // JAL at 0x100 with +0x40
    jal100_en = 1; gnt_prob = 100; ready_prob = 100; lat_min = 2; lat_max = 2;
    do_reset(0);
    run(15);
`ifdef JAL_PREDICT_EN
    chk("t5_next_addr", gnt_log[1], 64'h140);
`else
    chk("t5_next_addr", gnt_log[1], 64'h104);
`endif
    jal100_en = 0;

    // randomized traffic with random redirects
    jal_rand_en = 1; gnt_prob = 70; ready_prob = 60; lat_min = 1; lat_max = 4;
    do_reset(0);
    x0 = n_xfer;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(99) < 3) begin
        redir_now = 1;
        redir_tgt = ($urandom_range(9) == 0) ? 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(15))
                                             : {32'h0, $urandom};
      end
      cycle();
    end
    chk("rand_progress", {63'h0, (n_xfer - x0) > 100}, 64'h1);
    jal_rand_en = 0;

    // asynchronous reset mid-WAIT with entries buffered, stale response afterwards
    gnt_prob = 100; ready_prob = 0; lat_min = 3; lat_max = 3;
    do_reset(0);
    reached = 0;
    for (int i = 0; i < 60 && !reached; i++) begin
      cycle();
      reached = (gnt_log.size() == 3) && pending;
    end
    chk("t6_setup_reached", {63'h0, reached}, 64'h1);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("t6_async");
    pend_cnt = 0;
    do_reset(1);
    ready_prob = 100;
    x0 = n_xfer;
    run(30);
    chk("t6_restart_addr", gnt_log[0], RST_PC);
    chk("t6_xfers", {63'h0, (n_xfer - x0) >= 5}, 64'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
